// File: rtl/tile_scheduler.sv
// rtl/tile_scheduler.sv - per-tile job scheduler: one background job, then one job per visible sprite, in raster tile order.
module tile_scheduler #(
  parameter int TILE_LOG2 = 4,
  parameter int TILES_X   = 40,
  parameter int TILES_Y   = 30,
  parameter int SPR_W     = 10,
  parameter int POS_W     = 16,
  parameter int TEX_W     = 8,
  parameter int Z_W       = 8,
  localparam int TX_W     = $clog2(TILES_X),
  localparam int TY_W     = $clog2(TILES_Y),
  localparam int S_W      = TILE_LOG2 + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_cr_we,
  input  logic [3:0]       i_cr_addr,
  input  logic [SPR_W-1:0] i_cr_value,
  input  logic             i_frame_start,
  output logic [SPR_W-1:0] o_spirit_idx,
  input  logic [POS_W-1:0] i_spr_x,
  input  logic [POS_W-1:0] i_spr_y,
  input  logic [TEX_W-1:0] i_spr_tex,
  input  logic [Z_W-1:0]   i_spr_z,
  output logic [TX_W-1:0]  o_tile_x,
  output logic [TY_W-1:0]  o_tile_y,
  input  logic [TEX_W-1:0] i_tile_tex,
  output logic             o_job_valid,
  input  logic             i_job_ready,
  output logic [TEX_W-1:0] o_job_tex,
  output logic [Z_W-1:0]   o_job_z,
  output logic [S_W-1:0]   o_job_start_x,
  output logic [S_W-1:0]   o_job_start_y,
  output logic             o_tile_done,
  output logic             o_frame_done,
  output logic             o_busy
);

  localparam int E_W = POS_W + 1;
  localparam logic [E_W-1:0] T_E = E_W'(1 << TILE_LOG2);
  localparam logic [S_W-1:0] T_S = S_W'(1 << TILE_LOG2);

  typedef enum logic [2:0] {IDLE, BG, FETCH, CHECK, ISSUE, DONE} state_t;

  state_t           state, state_next;
  logic             render_ena, mode;
  logic [SPR_W-1:0] spr_cnt, cnt_q;

  logic [E_W-1:0] ox, oy, x_e, y_e, x_end, y_end;
  logic [S_W-1:0] sx_next, sy_next;
  logic           visible, last_spr, last_col, last_row, accept;

  // Coordinates are widened by one bit so x+T never wraps.
  assign ox      = E_W'(o_tile_x) << TILE_LOG2;
  assign oy      = E_W'(o_tile_y) << TILE_LOG2;
  assign x_e     = {1'b0, i_spr_x};
  assign y_e     = {1'b0, i_spr_y};
  assign x_end   = x_e + T_E;
  assign y_end   = y_e + T_E;
  assign sx_next = S_W'(x_end - ox);
  assign sy_next = S_W'(y_end - oy);
  assign visible = (i_spr_z != '0) && (x_end > ox) && (x_e < ox + T_E)
                && (y_end > oy) && (y_e < oy + T_E);

  assign last_spr = (o_spirit_idx == cnt_q);
  assign last_col = (o_tile_x == TX_W'(TILES_X - 1));
  assign last_row = (o_tile_y == TY_W'(TILES_Y - 1));
  assign accept   = o_job_valid && i_job_ready;

  assign o_tile_done  = (state == DONE);
  assign o_frame_done = (state == DONE) && last_col && last_row;
  assign o_busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (render_ena && (mode || i_frame_start)) state_next = BG;
      BG:    if (accept) state_next = (cnt_q == '0) ? DONE : FETCH;
      FETCH: state_next = CHECK;
      CHECK: if (visible)       state_next = ISSUE;
             else if (last_spr) state_next = DONE;
             else               state_next = FETCH;
      ISSUE: if (i_job_ready) state_next = last_spr ? DONE : FETCH;
      DONE:  if (last_col && last_row) state_next = (mode && render_ena) ? BG : IDLE;
             else                      state_next = render_ena ? BG : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      render_ena    <= 1'b1;
      mode          <= 1'b1;
      spr_cnt       <= SPR_W'(2);
      cnt_q         <= '0;
      o_tile_x      <= '0;
      o_tile_y      <= '0;
      o_spirit_idx  <= '0;
      o_job_valid   <= 1'b0;
      o_job_tex     <= '0;
      o_job_z       <= '0;
      o_job_start_x <= '0;
      o_job_start_y <= '0;
    end else begin
      if (i_cr_we) begin
        case (i_cr_addr)
          4'h0: render_ena <= i_cr_value[0];
          4'h4: mode       <= i_cr_value[0];
          4'h8: spr_cnt    <= i_cr_value;
          default: ;
        endcase
      end

      if (state_next == BG && state != BG) cnt_q <= spr_cnt;

      if (state_next == FETCH && state != FETCH)
        o_spirit_idx <= (state == BG) ? SPR_W'(1) : o_spirit_idx + SPR_W'(1);

      // BG spends its first cycle registering the tilemap texture of the new tile.
      case (state)
        BG: begin
          if (!o_job_valid) begin
            o_job_valid   <= 1'b1;
            o_job_tex     <= i_tile_tex;
            o_job_z       <= '0;
            o_job_start_x <= T_S;
            o_job_start_y <= T_S;
          end else if (i_job_ready) begin
            o_job_valid <= 1'b0;
          end
        end
        CHECK: if (visible) begin
          o_job_valid   <= 1'b1;
          o_job_tex     <= i_spr_tex;
          o_job_z       <= i_spr_z;
          o_job_start_x <= sx_next;
          o_job_start_y <= sy_next;
        end
        ISSUE: if (i_job_ready) o_job_valid <= 1'b0;
        DONE: begin
          if (last_col) begin
            o_tile_x <= '0;
            o_tile_y <= last_row ? '0 : o_tile_y + TY_W'(1);
          end else begin
            o_tile_x <= o_tile_x + TX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_scheduler.sv
// tb/tb_tile_scheduler.sv - scoreboard bench for tile_scheduler with directed sprite/tile vectors.
module tb_tile_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_cr_we = 1'b0;
  logic [3:0] i_cr_addr = '0;
  logic [9:0] i_cr_value = '0;
  logic       i_frame_start = 1'b0;
  logic [9:0] o_spirit_idx;
  logic [15:0] i_spr_x = '0, i_spr_y = '0;
  logic [7:0] i_spr_tex = '0, i_spr_z = '0;
  logic [5:0] o_tile_x;
  logic [4:0] o_tile_y;
  logic [7:0] i_tile_tex;
  logic       o_job_valid;
  logic       i_job_ready = 1'b0;
  logic [7:0] o_job_tex, o_job_z;
  logic [4:0] o_job_start_x, o_job_start_y;
  logic       o_tile_done, o_frame_done, o_busy;

  typedef struct packed {
    logic [7:0] tex;
    logic [7:0] z;
    logic [4:0] sx;
    logic [4:0] sy;
  } job_t;

  typedef struct packed {
    logic [5:0] x;
    logic [4:0] y;
    logic       f;
  } tile_t;

  job_t  exp_jobs[$];
  tile_t exp_tiles[$];

  logic [15:0] tbl_x[16];
  logic [15:0] tbl_y[16];
  logic [7:0]  tbl_tex[16];
  logic [7:0]  tbl_z[16];

  int n_vec = 0;
  int n_err = 0;
  int bg_count = 0;

  tile_scheduler dut (
    .clk(clk), .reset(reset),
    .i_cr_we(i_cr_we), .i_cr_addr(i_cr_addr), .i_cr_value(i_cr_value),
    .i_frame_start(i_frame_start), .o_spirit_idx(o_spirit_idx),
    .i_spr_x(i_spr_x), .i_spr_y(i_spr_y), .i_spr_tex(i_spr_tex), .i_spr_z(i_spr_z),
    .o_tile_x(o_tile_x), .o_tile_y(o_tile_y), .i_tile_tex(i_tile_tex),
    .o_job_valid(o_job_valid), .i_job_ready(i_job_ready),
    .o_job_tex(o_job_tex), .o_job_z(o_job_z),
    .o_job_start_x(o_job_start_x), .o_job_start_y(o_job_start_y),
    .o_tile_done(o_tile_done), .o_frame_done(o_frame_done), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] tm(input int x, input int y);
    return 8'(x * 5 + y * 11 + 3);
  endfunction

  assign i_tile_tex = tm(int'(o_tile_x), int'(o_tile_y));

  // Sprite table with one cycle of read latency.
  always @(posedge clk) begin
    i_spr_x   <= tbl_x[o_spirit_idx[3:0]];
    i_spr_y   <= tbl_y[o_spirit_idx[3:0]];
    i_spr_tex <= tbl_tex[o_spirit_idx[3:0]];
    i_spr_z   <= tbl_z[o_spirit_idx[3:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  job_t  prev_payload;
  logic  prev_pend = 1'b0;

  always @(negedge clk) begin
    job_t  cur, ej;
    tile_t ct, et;
    cur = {o_job_tex, o_job_z, o_job_start_x, o_job_start_y};
    ct  = {o_tile_x, o_tile_y, o_frame_done};
    if (reset) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        check("hold_valid", 32'(o_job_valid), 32'd1);
        check("hold_payload", 32'(cur), 32'(prev_payload));
      end
      if (o_job_valid && i_job_ready) begin
        if (exp_jobs.size() == 0) flag("unexpected_job");
        else begin
          ej = exp_jobs.pop_front();
          check("job", 32'(cur), 32'(ej));
        end
        if (o_job_z == 8'd0) bg_count++;
      end
      if (o_tile_done) begin
        if (exp_tiles.size() == 0) flag("unexpected_tile_done");
        else begin
          et = exp_tiles.pop_front();
          check("tile_done", 32'(ct), 32'(et));
        end
      end
      if (o_frame_done && !o_tile_done) flag("frame_done_without_tile_done");
      prev_pend    = o_job_valid && !i_job_ready;
      prev_payload = cur;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [9:0] v);
    cyc();
    i_cr_we = 1'b1; i_cr_addr = a; i_cr_value = v;
    cyc();
    i_cr_we = 1'b0;
  endtask

  task automatic pulse_fs();
    cyc();
    i_frame_start = 1'b1;
    cyc();
    i_frame_start = 1'b0;
  endtask

  // sel: 0 busy, 1 idle, 2 frame_done, 3 sprite job offered, 4 any job offered
  task automatic wait_for(input int sel, input int max);
    bit hit = 1'b0;
    for (int i = 0; i < max && !hit; i++) begin
      case (sel)
        0: hit = o_busy;
        1: hit = !o_busy;
        2: hit = o_frame_done;
        3: hit = o_job_valid && (o_job_z != 8'd0);
        default: hit = o_job_valid;
      endcase
      if (!hit) cyc();
    end
    if (!hit) flag($sformatf("timeout_wait_%0d", sel));
  endtask

  task automatic push_bg(input int x, input int y);
    exp_jobs.push_back({tm(x, y), 8'd0, 5'd16, 5'd16});
  endtask

  task automatic push_tile(input int x, input int y, input logic f);
    exp_tiles.push_back({6'(x), 5'(y), f});
  endtask

  task automatic set_spr(input int i, input int x, input int y, input int tex, input int z);
    tbl_x[i] = 16'(x); tbl_y[i] = 16'(y); tbl_tex[i] = 8'(tex); tbl_z[i] = 8'(z);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) set_spr(i, 0, 0, 0, 0);
    set_spr(1, 8, 8, 8'h11, 5);
    set_spr(2, 100, 100, 8'h22, 0);

    repeat (3) cyc();
    check("rst_valid", 32'(o_job_valid), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_pulses", 32'({o_tile_done, o_frame_done}), 32'd0);
    check("rst_tile", 32'({o_tile_x, o_tile_y}), 32'd0);
    check("rst_idx", 32'(o_spirit_idx), 32'd0);
    check("rst_payload", 32'({o_job_tex, o_job_z, o_job_start_x, o_job_start_y}), 32'd0);

    // Tile (0,0): background, sprite 1 visible, sprite 2 disabled; stop after the tile.
    push_bg(0, 0);
    exp_jobs.push_back({8'h11, 8'd5, 5'd24, 5'd24});
    push_tile(0, 0, 1'b0);
    reset = 1'b0;
    wr(4'h0, 10'd0);
    i_job_ready = 1'b1;
    wait_for(1, 200);
    check("idle_tile_1_0", 32'({o_tile_x, o_tile_y}), 32'({6'd1, 5'd0}));

    // Tile (1,0): sprite job held for 5 cycles of backpressure.
    push_bg(1, 0);
    exp_jobs.push_back({8'h11, 8'd5, 5'd8, 5'd24});
    push_tile(1, 0, 1'b0);
    wr(4'h0, 10'd1);
    wait_for(3, 200);
    i_job_ready = 1'b0;
    wr(4'h0, 10'd0);
    repeat (3) cyc();
    i_job_ready = 1'b1;
    wait_for(1, 200);
    check("idle_tile_2_0", 32'({o_tile_x, o_tile_y}), 32'({6'd2, 5'd0}));

    // Tile (2,0), ox=32: x=15 just misses, x=17 overlaps by one pixel.
    set_spr(1, 15, 0, 8'h33, 1);
    set_spr(2, 17, 0, 8'h44, 2);
    push_bg(2, 0);
    exp_jobs.push_back({8'h44, 8'd2, 5'd1, 5'd16});
    push_tile(2, 0, 1'b0);
    wr(4'h0, 10'd1);
    wait_for(0, 50);
    wr(4'h0, 10'd0);
    wait_for(1, 200);
    check("idle_tile_3_0", 32'({o_tile_x, o_tile_y}), 32'({6'd3, 5'd0}));

    // Tile (3,0): render_ena cleared mid-tile, tile still completes.
    set_spr(1, 15, 0, 8'h33, 0);
    set_spr(2, 17, 0, 8'h44, 0);
    push_bg(3, 0);
    push_tile(3, 0, 1'b0);
    wr(4'h0, 10'd1);
    wait_for(0, 50);
    wr(4'h0, 10'd0);
    wait_for(1, 200);
    check("idle_busy", 32'(o_busy), 32'd0);
    check("idle_tile_4_0", 32'({o_tile_x, o_tile_y}), 32'({6'd4, 5'd0}));

    // Resume at (4,0) with no sprites, switch to single-frame mode mid-frame.
    wr(4'h8, 10'd0);
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 40; x++)
        if (y * 40 + x >= 4) begin
          push_bg(x, y);
          push_tile(x, y, (x == 39) && (y == 29));
        end
    wr(4'h0, 10'd1);
    wait_for(0, 50);
    check("resume_tile", 32'({o_tile_x, o_tile_y}), 32'({6'd4, 5'd0}));
    wr(4'h4, 10'd0);
    pulse_fs();
    wait_for(2, 6000);
    wait_for(1, 10);
    check("frame_end_tile", 32'({o_tile_x, o_tile_y}), 32'd0);
    repeat (20) cyc();
    check("single_idle", 32'(o_busy), 32'd0);
    check("q_jobs_empty_1", 32'(exp_jobs.size()), 32'd0);

    // One full frame on frame_start; a second pulse mid-frame is ignored.
    bg_count = 0;
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 40; x++) begin
        push_bg(x, y);
        push_tile(x, y, (x == 39) && (y == 29));
      end
    pulse_fs();
    wait_for(0, 10);
    repeat (100) cyc();
    pulse_fs();
    wait_for(2, 6000);
    wait_for(1, 10);
    check("bg_jobs_frame", 32'(bg_count), 32'd1200);
    check("wrap_tile", 32'({o_tile_x, o_tile_y}), 32'd0);
    repeat (20) cyc();
    check("no_restart", 32'(o_busy), 32'd0);
    check("q_tiles_empty", 32'(exp_tiles.size()), 32'd0);

    // Reset while a job is offered and not accepted.
    i_job_ready = 1'b0;
    push_bg(0, 0);
    wr(4'h4, 10'd1);
    wait_for(4, 50);
    reset = 1'b1;
    cyc();
    check("rst_mid_valid", 32'(o_job_valid), 32'd0);
    check("rst_mid_pulse", 32'({o_tile_done, o_frame_done}), 32'd0);
    check("rst_mid_busy", 32'(o_busy), 32'd0);
    void'(exp_jobs.pop_back());
    check("q_jobs_empty_2", 32'(exp_jobs.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
